// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//
// Purpose:
//   UART transmit framer. It accepts one byte per request and wraps it in a
//   start bit and a stop bit. When the build enables it, it also adds an
//   optional parity bit. It does not shift the data bits itself. An external
//   serializer presents the data bits on ser_data while ser_en is high, and
//   raises ser_done on the cycle it presents its last bit.
//
// Build option:
//   UART_TX_PARITY_EN  - when defined, the PAR_EN/PAR_TYP ports, their
//                        latches and the PARITY state exist. When undefined,
//                        every frame is start + 8 data + stop (10 cycles).
//
// Ports:
//   clk         in   1  sole clock, rising edge
//   rst         in   1  asynchronous, active-high reset
//   P_Data      in   8  byte to transmit, sampled on acceptance
//   Data_Valid  in   1  request, honoured only in IDLE
//   PAR_EN      in   1  append parity bit      (UART_TX_PARITY_EN only)
//   PAR_TYP     in   1  0 = even, 1 = odd      (UART_TX_PARITY_EN only)
//   ser_data    in   1  current data bit from the serializer
//   ser_done    in   1  serializer is presenting its final bit
//   ser_en      out  1  serializer enable (START and DATA)
//   ser_pdata   out  8  latched byte for the serializer
//   TX_OUT      out  1  UART line, idle high
//   busy        out  1  frame in progress
// -----------------------------------------------------------------------------
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | line high, waiting for Data_Valid
//   START  | one cycle of start bit (0), serializer enabled
//   DATA   | line follows ser_data until ser_done is sampled
//   PARITY | one cycle of parity bit (parity builds only)
//   STOP   | one cycle of stop bit (1), then back to IDLE
//
module uart_tx_frame (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] P_Data,
    input  logic       Data_Valid,
`ifdef UART_TX_PARITY_EN
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
`endif
    input  logic       ser_data,
    input  logic       ser_done,
    output logic       ser_en,
    output logic [7:0] ser_pdata,
    output logic       TX_OUT,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_pdata;
    logic       w_accept;

`ifdef UART_TX_PARITY_EN
    logic       r_par_en;
    logic       r_par_typ;
    logic       w_parity_bit;

    // The parity bit comes from the latched copy only. Live inputs may
    // already belong to the next request.
    assign w_parity_bit = (^r_pdata) ^ r_par_typ;
`endif

    assign w_accept  = (r_state == S_IDLE) && Data_Valid;
    assign ser_pdata = r_pdata;

    // -------------------------------------------------------------------------
    // State register and acceptance latches
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pdata <= 8'h00;
        end else if (w_accept) begin
            r_pdata <= P_Data;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else if (w_accept) begin
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next state and outputs. The outputs depend on the state register (plus
    // ser_data in DATA) and never on the request inputs. A reset therefore
    // drops the line back to idle within the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        TX_OUT       = 1'b1;
        busy         = 1'b0;
        ser_en       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (Data_Valid) begin
                    w_next_state = S_START;
                end
            end

            S_START: begin
                TX_OUT       = 1'b0;
                busy         = 1'b1;
                ser_en       = 1'b1;
                w_next_state = S_DATA;
            end

            S_DATA: begin
                TX_OUT = ser_data;
                busy   = 1'b1;
                ser_en = 1'b1;
                // The serializer decides when the byte is done. An early
                // ser_done still ends the data phase.
                if (ser_done) begin
`ifdef UART_TX_PARITY_EN
                    w_next_state = r_par_en ? S_PARITY : S_STOP;
`else
                    w_next_state = S_STOP;
`endif
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                TX_OUT       = w_parity_bit;
                busy         = 1'b1;
                w_next_state = S_STOP;
            end
`endif

            S_STOP: begin
                TX_OUT       = 1'b1;
                busy         = 1'b1;
                w_next_state = S_IDLE;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
//
// Purpose:
//   Directed testbench for uart_tx_frame. A table of frame vectors lists the
//   expected line waveforms, worked out by hand. Hand-written sequences cover
//   a reset that aborts a frame and a request made while reset is held.
//   A small serializer model shifts the DUT's latched byte out LSB first.
//   It can also raise ser_done early when a test asks for it.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_Data;
    logic       Data_Valid;
`ifdef UART_TX_PARITY_EN
    logic       PAR_EN;
    logic       PAR_TYP;
`endif
    logic       ser_data;
    logic       ser_done;
    logic       ser_en;
    logic [7:0] ser_pdata;
    logic       TX_OUT;
    logic       busy;

    int n_total = 0;
    int n_pass  = 0;

    uart_tx_frame dut (
        .clk        (clk),
        .rst        (rst),
        .P_Data     (P_Data),
        .Data_Valid (Data_Valid),
`ifdef UART_TX_PARITY_EN
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
`endif
        .ser_data   (ser_data),
        .ser_done   (ser_done),
        .ser_en     (ser_en),
        .ser_pdata  (ser_pdata),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Serializer model. en_cnt counts the cycles in which ser_en has been
    // high. START is cycle 0. Data bit k is presented when en_cnt = k+1.
    int         en_cnt;
    int         early_at;
    logic [2:0] bit_idx;

    always @(posedge clk or posedge rst) begin
        if (rst)         en_cnt <= 0;
        else if (ser_en) en_cnt <= en_cnt + 1;
        else             en_cnt <= 0;
    end

    always_comb begin
        bit_idx  = 3'(en_cnt - 1);
        ser_data = 1'b0;
        if (en_cnt >= 1 && en_cnt <= 8) ser_data = ser_pdata[bit_idx];
        ser_done = (en_cnt == 8) || (early_at != 0 && en_cnt == early_at);
    end

    typedef struct {
        string       name;
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        int          len;     // cycles from START to end of STOP
        int          n_en;    // cycles with ser_en high
        int          dv_at;   // frame cycle carrying a stray request, -1 none
        int          early;   // en_cnt at which ser_done is forced, 0 none
        logic [0:10] exp;     // TX_OUT per frame cycle, left to right
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string name, input logic [7:0] d, input logic pe, input logic pt,
                       input int len, input int n_en, input int dv_at, input int early,
                       input logic [0:10] exp);
        vec_t v;
        v.name = name; v.data = d; v.par_en = pe; v.par_typ = pt; v.len = len;
        v.n_en = n_en; v.dv_at = dv_at; v.early = early; v.exp = exp;
        vecs.push_back(v);
    endtask

    // Run one frame. The task is entered just after a clock edge with the
    // DUT in IDLE. It returns after three IDLE cycles have been checked.
    task automatic run_vec(input vec_t v);
        early_at   = v.early;
        P_Data     = v.data;
`ifdef UART_TX_PARITY_EN
        PAR_EN     = v.par_en;
        PAR_TYP    = v.par_typ;
`endif
        Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        for (int i = 0; i < v.len; i++) begin
            chk($sformatf("%s tx[%0d]", v.name, i), {7'd0, TX_OUT}, {7'd0, v.exp[i]});
            chk($sformatf("%s busy[%0d]", v.name, i), {7'd0, busy}, 8'd1);
            chk($sformatf("%s ser_en[%0d]", v.name, i), {7'd0, ser_en},
                {7'd0, (i < v.n_en) ? 1'b1 : 1'b0});
            if (i == 0) chk({v.name, " ser_pdata"}, ser_pdata, v.data);
            // Disturb the live inputs once the frame has started. The frame
            // must not notice.
            if (i == 1) begin
                P_Data = ~v.data;
`ifdef UART_TX_PARITY_EN
                PAR_EN  = ~v.par_en;
                PAR_TYP = ~v.par_typ;
`endif
            end
            if (i == v.dv_at) begin
                P_Data     = 8'hFF;
                Data_Valid = 1'b1;
            end else if (i == v.dv_at + 1) begin
                Data_Valid = 1'b0;
            end
            step();
        end
        Data_Valid = 1'b0;
        early_at   = 0;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("%s idle busy[%0d]", v.name, j), {7'd0, busy}, 8'd0);
            chk($sformatf("%s idle tx[%0d]", v.name, j), {7'd0, TX_OUT}, 8'd1);
            if (j < 2) step();
        end
    endtask

    initial begin
        vec_t v;

        // Expected line sequences: start, data LSB first, [parity], stop.
        add("a5_nopar", 8'hA5, 1'b0, 1'b0, 10, 9, -1, 0, 11'b01010010110);
        add("00_nopar", 8'h00, 1'b0, 1'b0, 10, 9, -1, 0, 11'b00000000010);
        add("ff_nopar", 8'hFF, 1'b0, 1'b0, 10, 9, -1, 0, 11'b01111111110);
        add("01_nopar", 8'h01, 1'b0, 1'b0, 10, 9, -1, 0, 11'b01000000010);
        add("00_stray", 8'h00, 1'b0, 1'b0, 10, 9,  3, 0, 11'b00000000010);
        add("a5_early", 8'hA5, 1'b0, 1'b0,  7, 6, -1, 5, 11'b01010011000);
`ifdef UART_TX_PARITY_EN
        add("a5_even",  8'hA5, 1'b1, 1'b0, 11, 9, -1, 0, 11'b01010010101);
        add("01_odd",   8'h01, 1'b1, 1'b1, 11, 9, -1, 0, 11'b01000000001);
        add("01_even",  8'h01, 1'b1, 1'b0, 11, 9, -1, 0, 11'b01000000011);
        add("80_odd",   8'h80, 1'b1, 1'b1, 11, 9, -1, 0, 11'b00000000101);
        add("00_odd",   8'h00, 1'b1, 1'b1, 11, 9, -1, 0, 11'b00000000011);
`endif

        rst        = 1'b1;
        P_Data     = 8'h00;
        Data_Valid = 1'b0;
        early_at   = 0;
`ifdef UART_TX_PARITY_EN
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
`endif
        #1;
        chk("reset tx", {7'd0, TX_OUT}, 8'd1);
        chk("reset busy", {7'd0, busy}, 8'd0);
        chk("reset ser_en", {7'd0, ser_en}, 8'd0);
        chk("reset ser_pdata", ser_pdata, 8'h00);
        step();
        step();
        rst = 1'b0;
        step();

        foreach (vecs[k]) run_vec(vecs[k]);

        // Reset in DATA cycle 4 aborts the frame at once.
        early_at   = 0;
        P_Data     = 8'hA5;
        Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("pre-abort busy", {7'd0, busy}, 8'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort tx", {7'd0, TX_OUT}, 8'd1);
        chk("abort busy", {7'd0, busy}, 8'd0);
        chk("abort ser_en", {7'd0, ser_en}, 8'd0);
        chk("abort ser_pdata", ser_pdata, 8'h00);

        // A request held across edges while reset is asserted is dropped.
        P_Data     = 8'h3C;
        Data_Valid = 1'b1;
        step();
        step();
        chk("dv in reset busy", {7'd0, busy}, 8'd0);
        chk("dv in reset pdata", ser_pdata, 8'h00);
        Data_Valid = 1'b0;
        rst        = 1'b0;
        step();
        chk("post-reset busy", {7'd0, busy}, 8'd0);

        // The first request after release gives a complete frame.
        v = vecs[0];
        v.name = "a5_after_rst";
        run_vec(v);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
UART_TX_FRAME -- requirements
Module: uart_tx_frame

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: P_Data  in  8  parallel byte to transmit.
REQ-004 SHALL have ports: Data_Valid  in  1  1-cycle request to send P_Data.
REQ-005 SHALL have ports: PAR_EN  in  1  1 = append parity bit (only with UART_TX_PARITY_EN).
REQ-006 SHALL have ports: PAR_TYP  in  1  0 = even, 1 = odd (only with UART_TX_PARITY_EN).
REQ-007 SHALL have ports: ser_data  in  1  bit from the serializer.
REQ-008 SHALL have ports: ser_done  in  1  serializer flag, high in the cycle its bit 7 is presented.
REQ-009 SHALL have ports: ser_en  out  1  serializer enable.
REQ-010 SHALL have ports: ser_pdata  out  8  latched byte driven to serializer P_Data.
REQ-011 SHALL have ports: TX_OUT  out  1  UART line, idle high.
REQ-012 SHALL have ports: busy  out  1  frame in progress.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP in a registered state variable.
- IDLE: TX_OUT=1, busy=0, ser_en=0.
- On Data_Valid=1, latch P_Data into ser_pdata; with UART_TX_PARITY_EN, also latch PAR_EN and PAR_TYP; go to START.
REQ-014 SHALL, in START, hold for exactly 1 cycle with TX_OUT=0, busy=1, ser_en=1, then go to DATA.
REQ-015 SHALL, in DATA, drive TX_OUT=ser_data, busy=1, ser_en=1, and remain in DATA until ser_done=1 is sampled.
- Normal case: exactly 8 cycles, bits presented LSB first.
REQ-016 SHALL, on ser_done=1 in DATA, go to PARITY if the latched PAR_EN=1, else go to STOP.
REQ-017 SHALL, in PARITY, hold for 1 cycle with TX_OUT = XOR of the 8 latched bits, inverted when the latched PAR_TYP=1; busy=1, ser_en=0; then go to STOP.
REQ-018 SHALL, in STOP, hold for 1 cycle with TX_OUT=1, busy=1, ser_en=0, then go to IDLE.
REQ-019 SHALL derive TX_OUT, busy and ser_en combinationally from the state register and ser_data only.
- No dependence on P_Data or Data_Valid after acceptance.
REQ-020 SHALL ignore Data_Valid in every state except IDLE; no queuing of requests.
REQ-021 SHALL ignore changes to P_Data, PAR_EN and PAR_TYP after acceptance for the remainder of the frame.
REQ-022 SHALL make frame length from acceptance edge to return to IDLE exactly 10 cycles without parity and 11 cycles with parity.
- Minimum gap between frames: 1 IDLE cycle.
REQ-023 SHALL, if ser_done is asserted before 8 DATA cycles, still leave DATA on that sample (serializer is authoritative).
REQ-024 SHALL use parity computed from the latched byte, never from live P_Data.

Reset
REQ-025 SHALL, while rst=1, force state=IDLE, ser_pdata=8'h00, TX_OUT=1, busy=0, ser_en=0, independent of clk.
REQ-026 SHALL, on reset asserted mid-frame, abort the frame immediately and return TX_OUT to 1 without finishing the stop bit.
REQ-027 SHALL ignore Data_Valid in the first clock edge on which rst is asserted.
- Acceptance is possible from the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL support compile-time macro UART_TX_PARITY_EN.
- Defined: PAR_EN and PAR_TYP ports, their latches and the PARITY state exist, behaving per REQ-016/017.
- Undefined: those ports, latches and the PARITY state are absent; DATA always goes to STOP; frame length is fixed at 10 cycles.

Verification
REQ-029 SHALL verify no parity: P_Data=8'hA5 with Data_Valid pulse, PAR_EN=0 -> TX_OUT over 10 cycles = 0,1,0,1,0,0,1,0,1,1; busy high 10 cycles.
REQ-030 SHALL verify even parity: P_Data=8'hA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0; frame = 0,1,0,1,0,0,1,0,1,0,1.
REQ-031 SHALL verify odd parity: P_Data=8'h01, PAR_EN=1, PAR_TYP=1 -> parity bit 0; PAR_TYP=0 -> parity bit 1.
REQ-032 SHALL verify ignored request: second Data_Valid with P_Data=8'hFF issued in DATA cycle 3 of an 8'h00 frame -> frame stays all-zero data; no second frame follows.
REQ-033 SHALL verify reset abort: rst asserted in DATA cycle 4 -> TX_OUT=1, busy=0, ser_en=0 in the same cycle; next Data_Valid after release produces a complete, correct frame.
